// File: rtl/spm_driver_if.sv
// Operand and product handshake channels between a requester and spm_driver.
// The slave modport is the driver's view; the master modport is the requester's.
interface spm_driver_if #(
    parameter int unsigned N = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_x;
    logic [N-1:0]     in_y;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_p;

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_p
    );

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_p
    );
endinterface

// File: rtl/spm_driver.sv
// Initiator for a serial-parallel multiplier: x is presented in parallel, y is shifted in LSB
// first with sign extension, and the serial product stream is gathered into a 2N-bit result.
module spm_driver #(
    parameter int unsigned N     = 8,
    parameter int unsigned P_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    spm_driver_if.slave  bus,
    output logic         spm_rst,
    output logic [N-1:0] spm_x,
    output logic         spm_y,
    input  logic         spm_p
);

    localparam int unsigned W    = 2 * N;
    localparam int unsigned CntW = $clog2(W + P_LAT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(W + P_LAT - 1);
    localparam logic [CntW-1:0] PLatCnt = CntW'(P_LAT);

    typedef enum logic [1:0] {StIdle, StClear, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    x_reg_q, x_reg_d;
    logic [N-1:0]    y_sr_q, y_sr_d;
    logic [W-1:0]    p_sr_q, p_sr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    out_p_q, out_p_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    always_comb begin
        state_d     = state_q;
        x_reg_d     = x_reg_q;
        y_sr_d      = y_sr_q;
        p_sr_d      = p_sr_q;
        cnt_d       = cnt_q;
        out_p_d     = out_p_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && in_ready_q) begin
                    x_reg_d    = bus.in_x;
                    y_sr_d     = bus.in_y;
                    in_ready_d = 1'b0;
                    state_d    = StClear;
                end
            end
            StClear: begin
                cnt_d   = '0;
                p_sr_d  = '0;
                state_d = StShift;
            end
            StShift: begin
                y_sr_d = {y_sr_q[N-1], y_sr_q[N-1:1]};
                cnt_d  = cnt_q + 1'b1;
                // The first P_LAT cycles carry nothing from the spm pipeline yet.
                if (cnt_q >= PLatCnt) begin
                    p_sr_d = {spm_p, p_sr_q[W-1:1]};
                end
                if (cnt_q == LastCnt) begin
                    out_p_d     = p_sr_d;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            x_reg_q     <= '0;
            y_sr_q      <= '0;
            p_sr_q      <= '0;
            cnt_q       <= '0;
            out_p_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_reg_q     <= x_reg_d;
            y_sr_q      <= y_sr_d;
            p_sr_q      <= p_sr_d;
            cnt_q       <= cnt_d;
            out_p_q     <= out_p_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign spm_rst       = rst | (state_q == StClear);
    assign spm_x         = x_reg_q;
    assign spm_y         = (state_q == StShift) & y_sr_q[0];
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;

endmodule
